// File: rtl/swc_page_alloc_arbiter_if.sv
// Port-side and core-side signal bundle for the page allocation arbiter.
// slave is the arbiter's view; master is the requester/core view.
interface swc_page_alloc_arbiter_if #(
    parameter int g_num_ports      = 11,
    parameter int g_page_addr_bits = 10,
    parameter int g_use_count_bits = 4
);
    // Requests are levels held until the matching one-cycle done pulse; the
    // core strobe is held with stable operands until core_done_i is seen.
    logic [g_num_ports-1:0]                  alloc_i;
    logic [g_num_ports-1:0]                  free_i;
    logic [g_num_ports*g_page_addr_bits-1:0] pgaddr_free_i;
    logic [g_num_ports*g_use_count_bits-1:0] usecnt_i;
    logic [g_num_ports-1:0]                  alloc_done_o;
    logic [g_num_ports-1:0]                  free_done_o;
    logic [g_page_addr_bits-1:0]             pgaddr_alloc_o;
    logic                                    core_alloc_o;
    logic                                    core_free_o;
    logic [g_page_addr_bits-1:0]             core_pgaddr_o;
    logic [g_use_count_bits-1:0]             core_usecnt_o;
    logic                                    core_done_i;
    logic [g_page_addr_bits-1:0]             core_pgaddr_i;

    modport slave (
        input  alloc_i, free_i, pgaddr_free_i, usecnt_i, core_done_i, core_pgaddr_i,
        output alloc_done_o, free_done_o, pgaddr_alloc_o,
        output core_alloc_o, core_free_o, core_pgaddr_o, core_usecnt_o
    );

    modport master (
        output alloc_i, free_i, pgaddr_free_i, usecnt_i, core_done_i, core_pgaddr_i,
        input  alloc_done_o, free_done_o, pgaddr_alloc_o,
        input  core_alloc_o, core_free_o, core_pgaddr_o, core_usecnt_o
    );
endinterface

// File: rtl/swc_page_alloc_arbiter.sv
// Round-robin arbiter funnelling N alloc/free requesters into one allocator core.
// Optional macro SWC_PGALLOC_FREE_PRIO_EN: frees win over all allocs.
module swc_page_alloc_arbiter #(
    parameter int g_num_ports      = 11,
    parameter int g_page_addr_bits = 10,
    parameter int g_use_count_bits = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    swc_page_alloc_arbiter_if.slave   bus,
    output logic [1:0]                state_dbg_o
);
    localparam int N = g_num_ports;
    localparam int A = g_page_addr_bits;
    localparam int U = g_use_count_bits;
    localparam int W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state, state_next;
    logic [W-1:0]   winner;
    logic           op_alloc;
    logic           just_done;
    logic [A-1:0]   pg_op;
    logic [U-1:0]   uc_op;
    logic [A-1:0]   pg_alloc;

    logic [N-1:0]   winner_vec;
    logic [N-1:0]   alloc_elig;
    logic [N-1:0]   free_elig;
    logic           grant_valid;
    logic [W-1:0]   grant_port;
    logic           grant_alloc;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            winner_vec[i] = (winner == W'(i));
        end
    end

    // The (port, op) just served is masked for one IDLE cycle so a requester
    // that drops its level one cycle late is not granted a second time.
    always_comb begin
        alloc_elig = bus.alloc_i & ~((just_done && op_alloc) ? winner_vec : '0);
        free_elig  = bus.free_i  & ~((just_done && !op_alloc) ? winner_vec : '0);
    end

    // Search starts one past the last winner, which doubles as the RR pointer.
    always_comb begin
        int           idx;
        logic [W-1:0] pidx;
        grant_valid = 1'b0;
        grant_port  = '0;
        grant_alloc = 1'b0;
        idx         = 0;
        pidx        = '0;
`ifdef SWC_PGALLOC_FREE_PRIO_EN
        for (int k = 0; k < N; k++) begin
            idx = int'(winner) + 1 + k;
            if (idx >= N) idx = idx - N;
            pidx = W'(idx);
            if (!grant_valid && free_elig[pidx]) begin
                grant_valid = 1'b1;
                grant_port  = pidx;
                grant_alloc = 1'b0;
            end
        end
        for (int k = 0; k < N; k++) begin
            idx = int'(winner) + 1 + k;
            if (idx >= N) idx = idx - N;
            pidx = W'(idx);
            if (!grant_valid && alloc_elig[pidx]) begin
                grant_valid = 1'b1;
                grant_port  = pidx;
                grant_alloc = 1'b1;
            end
        end
`else
        for (int k = 0; k < N; k++) begin
            idx = int'(winner) + 1 + k;
            if (idx >= N) idx = idx - N;
            pidx = W'(idx);
            if (!grant_valid && (alloc_elig[pidx] || free_elig[pidx])) begin
                grant_valid = 1'b1;
                grant_port  = pidx;
                grant_alloc = alloc_elig[pidx];
            end
        end
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_next;
    end

    // Strobes and done pulses decode straight from state so reset drops them at once.
    always_comb begin
        state_next       = state;
        bus.core_alloc_o = 1'b0;
        bus.core_free_o  = 1'b0;
        bus.alloc_done_o = '0;
        bus.free_done_o  = '0;
        case (state)
            S_IDLE: begin
                if (grant_valid) state_next = S_BUSY;
            end
            S_BUSY: begin
                bus.core_alloc_o = op_alloc;
                bus.core_free_o  = !op_alloc;
                if (bus.core_done_i) state_next = S_DONE;
            end
            S_DONE: begin
                bus.alloc_done_o = op_alloc ? winner_vec : '0;
                bus.free_done_o  = op_alloc ? '0 : winner_vec;
                state_next       = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            winner    <= W'(N - 1);
            op_alloc  <= 1'b0;
            just_done <= 1'b0;
            pg_op     <= '0;
            uc_op     <= '0;
            pg_alloc  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    just_done <= 1'b0;
                    if (grant_valid) begin
                        winner   <= grant_port;
                        op_alloc <= grant_alloc;
                        pg_op    <= grant_alloc ? '0 : bus.pgaddr_free_i[grant_port*A +: A];
                        uc_op    <= grant_alloc ? bus.usecnt_i[grant_port*U +: U] : '0;
                    end
                end
                S_BUSY: begin
                    if (bus.core_done_i && op_alloc) pg_alloc <= bus.core_pgaddr_i;
                end
                S_DONE: begin
                    just_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.core_pgaddr_o  = pg_op;
    assign bus.core_usecnt_o  = uc_op;
    assign bus.pgaddr_alloc_o = pg_alloc;
    assign state_dbg_o        = state;
endmodule

// File: tb/tb_swc_page_alloc_arbiter.sv
// Directed bench for swc_page_alloc_arbiter: reset, single op, RR order,
// alloc/free ordering, late drop, mid-BUSY reset and two-port alternation.
module tb_swc_page_alloc_arbiter;
    localparam int N = 11;
    localparam int A = 10;
    localparam int U = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg;
    int         checks = 0;
    int         errors = 0;
    logic [A-1:0] exp_pg_alloc = '0;

    swc_page_alloc_arbiter_if #(.g_num_ports(N), .g_page_addr_bits(A), .g_use_count_bits(U)) bus ();

    swc_page_alloc_arbiter #(.g_num_ports(N), .g_page_addr_bits(A), .g_use_count_bits(U)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus.slave),
        .state_dbg_o (dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Waits for the core strobe, checks operands, completes the op and checks
    // the done pulse. mode 0: drop request at done, 1: drop one cycle later, 2: keep.
    task automatic serve(input int p, input bit is_alloc, input logic [A-1:0] pg,
                         input logic [U-1:0] uc, input int busy, input logic [A-1:0] ret,
                         input int mode);
        int          waited;
        logic [N-1:0] mask;
        waited = 0;
        mask   = N'(1) << p;
        while (!(bus.core_alloc_o || bus.core_free_o) && waited < 30) begin
            tick();
            waited++;
        end
        chk("strobe_seen", 32'(bus.core_alloc_o | bus.core_free_o), 1);
        chk("core_alloc", 32'(bus.core_alloc_o), 32'(is_alloc));
        chk("core_free", 32'(bus.core_free_o), 32'(!is_alloc));
        if (is_alloc) chk("core_usecnt", 32'(bus.core_usecnt_o), 32'(uc));
        else          chk("core_pgaddr", 32'(bus.core_pgaddr_o), 32'(pg));
        bus.core_pgaddr_i = ret;
        for (int i = 1; i < busy; i++) begin
            tick();
            chk("strobe_held", 32'(is_alloc ? bus.core_alloc_o : bus.core_free_o), 1);
        end
        bus.core_done_i = 1'b1;
        tick();
        bus.core_done_i   = 1'b0;
        bus.core_pgaddr_i = '1;
        if (is_alloc) exp_pg_alloc = ret;
        chk("alloc_done", 32'(bus.alloc_done_o), is_alloc ? 32'(mask) : 0);
        chk("free_done", 32'(bus.free_done_o), is_alloc ? 0 : 32'(mask));
        chk("strobe_off", 32'(bus.core_alloc_o | bus.core_free_o), 0);
        chk("pgaddr_alloc", 32'(bus.pgaddr_alloc_o), 32'(exp_pg_alloc));
        if (mode == 1) begin
            tick();
            if (is_alloc) bus.alloc_i[p] = 1'b0;
            else          bus.free_i[p]  = 1'b0;
            tick();
            chk("no_regrant", 32'(bus.core_alloc_o | bus.core_free_o), 0);
        end else begin
            if (mode == 0) begin
                if (is_alloc) bus.alloc_i[p] = 1'b0;
                else          bus.free_i[p]  = 1'b0;
            end
            tick();
        end
        chk("done_one_cycle", 32'(bus.alloc_done_o | bus.free_done_o), 0);
        chk("pgaddr_alloc_held", 32'(bus.pgaddr_alloc_o), 32'(exp_pg_alloc));
    endtask

    initial begin
        int waited;
        bus.alloc_i       = '0;
        bus.free_i        = '0;
        bus.pgaddr_free_i = '0;
        bus.usecnt_i      = '0;
        bus.core_done_i   = 1'b0;
        bus.core_pgaddr_i = '0;
        rst = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_state", 32'(dbg), 0);
        chk("rst_alloc_done", 32'(bus.alloc_done_o), 0);
        chk("rst_free_done", 32'(bus.free_done_o), 0);
        chk("rst_strobes", 32'(bus.core_alloc_o | bus.core_free_o), 0);
        chk("rst_core_pgaddr", 32'(bus.core_pgaddr_o), 0);
        chk("rst_core_usecnt", 32'(bus.core_usecnt_o), 0);
        chk("rst_pgaddr_alloc", 32'(bus.pgaddr_alloc_o), 0);
        rst = 1'b0;
        tick();

        // All ports alloc together: grants 0..10 in order
        for (int p = 0; p < N; p++) begin
            bus.usecnt_i[p*U +: U]      = U'(p);
            bus.pgaddr_free_i[p*A +: A] = A'(p + 1);
        end
        bus.alloc_i = '1;
        for (int p = 0; p < N; p++) begin
            serve(p, 1'b1, '0, U'(p), 1, A'(10'h100 + p), 0);
        end
        chk("all_served", 32'(bus.alloc_i), 0);

        // Single alloc on port 5, core busy 3 cycles
        bus.usecnt_i[5*U +: U] = 4'd2;
        bus.alloc_i[5] = 1'b1;
        tick();
        chk("latency_strobe", 32'(bus.core_alloc_o), 1);
        serve(5, 1'b1, '0, 4'd2, 3, 10'h07B, 0);

        // Port 3 alloc and free together
        bus.usecnt_i[3*U +: U]      = 4'd7;
        bus.pgaddr_free_i[3*A +: A] = 10'h1FF;
        bus.alloc_i[3] = 1'b1;
        bus.free_i[3]  = 1'b1;
`ifdef SWC_PGALLOC_FREE_PRIO_EN
        serve(3, 1'b0, 10'h1FF, '0, 1, 10'h155, 0);
        serve(3, 1'b1, '0, 4'd7, 2, 10'h2A0, 0);
`else
        serve(3, 1'b1, '0, 4'd7, 2, 10'h2A0, 0);
        serve(3, 1'b0, 10'h1FF, '0, 1, 10'h155, 0);
`endif

        // Port 8 drops alloc one cycle after done
        bus.usecnt_i[8*U +: U] = 4'd1;
        bus.alloc_i[8] = 1'b1;
        serve(8, 1'b1, '0, 4'd1, 2, 10'h033, 1);

        // Reset while core_free_o is high on port 4
        bus.pgaddr_free_i[4*A +: A] = 10'h0AA;
        bus.free_i[4] = 1'b1;
        waited = 0;
        while (!bus.core_free_o && waited < 30) begin
            tick();
            waited++;
        end
        chk("pre_rst_free", 32'(bus.core_free_o), 1);
        chk("pre_rst_pgaddr", 32'(bus.core_pgaddr_o), 32'h0AA);
        rst = 1'b1;
        #1;
        chk("rst_drop_free", 32'(bus.core_free_o), 0);
        chk("rst_core_pgaddr_clr", 32'(bus.core_pgaddr_o), 0);
        exp_pg_alloc = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_no_free_done", 32'(bus.free_done_o), 0);
        end
        chk("rst_pgaddr_alloc_clr", 32'(bus.pgaddr_alloc_o), 0);
        bus.free_i[4] = 1'b0;
        rst = 1'b0;
        tick();

        // Stray core_done in IDLE is ignored
        bus.core_done_i = 1'b1;
        tick();
        bus.core_done_i = 1'b0;
        chk("idle_done_ignored", 32'(dbg), 0);
        tick();
        chk("idle_no_pulse", 32'(bus.alloc_done_o | bus.free_done_o), 0);

        // After reset port 0 is searched first
        bus.usecnt_i[0*U +: U] = 4'd9;
        bus.usecnt_i[6*U +: U] = 4'd6;
        bus.alloc_i[0] = 1'b1;
        bus.alloc_i[6] = 1'b1;
        serve(0, 1'b1, '0, 4'd9, 1, 10'h011, 0);
        serve(6, 1'b1, '0, 4'd6, 1, 10'h066, 0);

        bus.usecnt_i[1*U +: U] = 4'd4;
        bus.alloc_i[1] = 1'b1;
        serve(1, 1'b1, '0, 4'd4, 1, 10'h0C1, 0);

        // Ports 2 and 9 alternate over 20 ops
        bus.usecnt_i[2*U +: U] = 4'd3;
        bus.usecnt_i[9*U +: U] = 4'd5;
        bus.alloc_i[2] = 1'b1;
        bus.alloc_i[9] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            serve((i % 2 == 1) ? 9 : 2, 1'b1, '0, (i % 2 == 1) ? 4'd5 : 4'd3, 1 + (i % 3),
                  A'(10'h040 + i), (i >= 18) ? 0 : 2);
        end

        for (int i = 0; i < 5; i++) begin
            tick();
        end
        chk("final_idle", 32'(dbg), 0);
        chk("final_strobes", 32'(bus.core_alloc_o | bus.core_free_o), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
